// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - handshake and operand/result bundle for serial_subtractor
//
// Purpose: groups the start/busy/done handshake with the operand and result buses.
// Signals:
//   start      request a new subtraction (sampled only while busy = 0)
//   a_in       minuend, WIDTH bits
//   b_in       subtrahend, WIDTH bits
//   borrow_in  initial borrow
//   busy       high while bits are being processed
//   done       one-cycle pulse, result valid from this cycle
//   diff_out   (a_in - b_in - borrow_in) mod 2^WIDTH
//   borrow_out final borrow
// Modports: master drives the request side, slave is the subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff_out;
   logic             borrow_out;

   modport master (
      output start, a_in, b_in, borrow_in,
      input  busy, done, diff_out, borrow_out
   );

   modport slave (
      input  start, a_in, b_in, borrow_in,
      output busy, done, diff_out, borrow_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one bit per clock
//
// Purpose: computes a_in - b_in - borrow_in through a single full-subtractor slice,
// feeding the slice borrow back through a flop. Result and final borrow are held
// until the next operation completes.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if.slave (start/a_in/b_in/borrow_in in,
//          busy/done/diff_out/borrow_out out)
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    count;

   logic             d;
   logic             bo;
   logic [WIDTH-1:0] next_res;

   // Full-subtractor slice on the current LSBs; the new difference bit enters
   // the result register at the MSB so that after WIDTH shifts bit 0 lands at 0.
   // The shift-and-or form stays legal for WIDTH = 1.
   always_comb begin
      d        = a_sh[0] ^ b_sh[0] ^ br;
      bo       = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
      next_res = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         a_sh           <= '0;
         b_sh           <= '0;
         res            <= '0;
         br             <= 1'b0;
         count          <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff_out   <= '0;
         bus.borrow_out <= 1'b0;
      end else begin
         case (state)
            // DONE behaves like IDLE for acceptance, which gives back-to-back starts.
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sh     <= bus.a_in;
                  b_sh     <= bus.b_in;
                  br       <= bus.borrow_in;
                  res      <= '0;
                  count    <= '0;
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            RUN: begin
               res  <= next_res;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= bo;
               if (count == CW'(WIDTH - 1)) begin
                  count          <= '0;
                  state          <= DONE;
                  bus.busy       <= 1'b0;
                  bus.done       <= 1'b1;
                  bus.diff_out   <= next_res;
                  bus.borrow_out <= bo;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 8 and WIDTH 3)
module tb_serial_subtractor;
   logic clk;
   logic rst_n;

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(3)) if3 ();

   serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int done3_cnt = 0;

   always @(negedge clk) if (if3.done === 1'b1) done3_cnt++;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain modular arithmetic and an unsigned compare.
   function automatic logic [7:0] ref_diff(input int a, input int b, input int bi, input int w);
      int r;
      r = (a - b - bi) & ((1 << w) - 1);
      return 8'(r);
   endfunction

   function automatic logic ref_borrow(input int a, input int b, input int bi);
      return (a < b + bi);
   endfunction

   // Launch an 8-bit op and wait for done. lat counts edges with the accepting edge as 1.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bo, output int lat, output int nbusy);
      @(negedge clk);
      if8.a_in = a; if8.b_in = b; if8.borrow_in = bi; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      lat = 1; nbusy = 0;
      while (lat < 40) begin
         if (if8.busy) nbusy++;
         if (if8.done) break;
         @(negedge clk);
         lat++;
      end
      d = if8.diff_out; bo = if8.borrow_out;
   endtask

   task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic bi,
                       output logic [2:0] d, output logic bo, output int lat);
      @(negedge clk);
      if3.a_in = a; if3.b_in = b; if3.borrow_in = bi; if3.start = 1'b1;
      @(negedge clk);
      if3.start = 1'b0;
      lat = 1;
      while (lat < 20 && !if3.done) begin
         @(negedge clk);
         lat++;
      end
      d = if3.diff_out; bo = if3.borrow_out;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [7:0] d8;
      logic       bo8;
      logic [2:0] d3;
      logic       bo3;
      int         lat;
      int         nb;
      logic       hold_ok;
      int         starts3;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

      // Reset held with start asserted: everything stays cleared.
      rst_n = 1'b0;
      if8.start = 1'b1; if8.a_in = 8'h5A; if8.b_in = 8'h3C; if8.borrow_in = 1'b0;
      if3.start = 1'b1; if3.a_in = 3'd0;  if3.b_in = 3'd0;  if3.borrow_in = 1'b0;
      #12;
      check("reset_busy", if8.busy, 0);
      check("reset_done", if8.done, 0);
      check("reset_diff", if8.diff_out, 0);
      check("reset_borrow", if8.borrow_out, 0);
      @(negedge clk);
      if8.start = 1'b0; if3.start = 1'b0;
      rst_n = 1'b1;

      // Table of directed vectors.
      for (int i = 0; i < 4; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].bi, d8, bo8, lat, nb);
         check($sformatf("vec%0d_diff", i), d8, vecs[i].d);
         check($sformatf("vec%0d_borrow", i), bo8, vecs[i].bo);
         check($sformatf("vec%0d_latency", i), lat, 9);
         check($sformatf("vec%0d_busy_cycles", i), nb, 8);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), if8.done, 0);
      end

      // Randomized ops against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         logic       rbi;
         ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
         run8(ra, rb, rbi, d8, bo8, lat, nb);
         check($sformatf("rand%0d_diff", i), d8, ref_diff(ra, rb, rbi, 8));
         check($sformatf("rand%0d_borrow", i), bo8, ref_borrow(ra, rb, rbi));
         check($sformatf("rand%0d_latency", i), lat, 9);
      end

      // Protocol: ignored start and input changes during RUN, then back-to-back start.
      @(negedge clk);
      if8.a_in = 8'h80; if8.b_in = 8'h01; if8.borrow_in = 1'b0; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      @(negedge clk);
      if8.a_in = 8'h00; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      lat = 3;
      while (lat < 40 && !if8.done) begin
         @(negedge clk);
         lat++;
      end
      check("proto1_latency", lat, 9);
      check("proto1_diff", if8.diff_out, 8'h7F);
      check("proto1_borrow", if8.borrow_out, 0);
      if8.a_in = 8'h03; if8.b_in = 8'h05; if8.borrow_in = 1'b0; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      check("b2b_accept_busy", if8.busy, 1);
      check("b2b_accept_done", if8.done, 0);
      lat = 1; hold_ok = 1'b1;
      while (lat < 40 && !if8.done) begin
         if (if8.diff_out !== 8'h7F || if8.borrow_out !== 1'b0) hold_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check("b2b_hold_during_run", hold_ok, 1);
      check("b2b_latency", lat, 9);
      check("b2b_diff", if8.diff_out, 8'hFE);
      check("b2b_borrow", if8.borrow_out, 1);
      @(negedge clk);
      check("b2b_idle_busy", if8.busy, 0);
      check("b2b_idle_done", if8.done, 0);

      // Reset after the 4th RUN edge, then a clean op.
      @(negedge clk);
      if8.a_in = 8'h5A; if8.b_in = 8'h3C; if8.borrow_in = 1'b0; if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      repeat (4) @(negedge clk);
      check("midrun_busy_before", if8.busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", if8.busy, 0);
      check("midrst_done", if8.done, 0);
      check("midrst_diff", if8.diff_out, 0);
      check("midrst_borrow", if8.borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run8(8'h5A, 8'h3C, 1'b0, d8, bo8, lat, nb);
      check("postrst_diff", d8, 8'h1E);
      check("postrst_borrow", bo8, 0);
      check("postrst_latency", lat, 9);

      // WIDTH = 3 exhaustive sweep.
      done3_cnt = 0;
      starts3 = 0;
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int bi = 0; bi < 2; bi++) begin
               run3(3'(a), 3'(b), 1'(bi), d3, bo3, lat);
               starts3++;
               check($sformatf("w3_%0d_%0d_%0d_diff", a, b, bi), d3, 3'(ref_diff(a, b, bi, 3)));
               check($sformatf("w3_%0d_%0d_%0d_borrow", a, b, bi), bo3, ref_borrow(a, b, bi));
            end
      repeat (3) @(negedge clk);
      check("w3_done_pulses", done3_cnt, starts3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes a_in − b_in − borrow_in, LSB first, one bit per clock.
- Each cycle it drives one full-subtractor bit slice (diff = a^b^c, borrow = ~a&b | ~(a^b)&c) and feeds that slice's borrow back through a flip-flop.
- It is the sequencing stage wrapped around the full-subtractor cell, used where area matters more than latency.
- Start/busy/done handshake; result is held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new subtraction; sampled only when busy = 0
- a_in  input  WIDTH  minuend; captured on the accepting edge
- b_in  input  WIDTH  subtrahend; captured on the accepting edge
- borrow_in  input  1  initial borrow; captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff_out/borrow_out are valid from this cycle
- diff_out  output  WIDTH  result (a_in − b_in − borrow_in) mod 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff a_in < b_in + borrow_in (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - State goes to IDLE.
  - busy, done, diff_out, borrow_out, internal shift registers, borrow flop and bit counter all go to 0.
  - Deassertion is synchronous to clk in the enclosing design.
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - DONE: busy = 0, done = 1, lasts exactly one cycle.
- IDLE → RUN on a clk edge with start = 1. That edge:
  - loads shift registers A ← a_in, B ← b_in;
  - sets borrow flop ← borrow_in;
  - clears the result shift register and sets count ← 0.
- In RUN, each edge:
  - forms d = A[0]^B[0]^br and bo = (~A[0]&B[0]) | (~(A[0]^B[0])&br);
  - shifts d into the result register at the MSB end (shift right);
  - shifts A and B right by one, sets br ← bo, and increments count.
- RUN → DONE on the edge that processes bit WIDTH−1, i.e. when count = WIDTH−1 before that edge. On the same edge:
  - diff_out ← final result (including this bit);
  - borrow_out ← bo.
- DONE → RUN if start = 1 on the next edge (back-to-back; inputs loaded as above). Otherwise DONE → IDLE.
- Latency: accepting edge E0; done is high in the cycle following edge E0+WIDTH. WIDTH = 8 gives done on the 9th edge counting E0 as the 1st. Throughput is one result per WIDTH+1 cycles.
- start while busy = 1 is ignored, with no effect on the current operation.
- Changes on a_in, b_in and borrow_in after the accepting edge have no effect.
- diff_out and borrow_out change only on the edge entering DONE, or on reset. They hold their previous value during RUN and IDLE.
- WIDTH = 1: RUN lasts one edge; the behaviour equals one full-subtractor evaluation with the outputs registered.
- Counter width is clog2(WIDTH) bits, minimum 1. Count never exceeds WIDTH−1.
- Unknown (X) values on start while in IDLE are a protocol violation; no recovery is specified.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle with start = 1 → busy = 0, done = 0, diff_out = 0x00, borrow_out = 0 immediately, without waiting for a clock edge.
- WIDTH = 8, a_in = 0x5A, b_in = 0x3C, borrow_in = 0, start pulsed one cycle:
  - busy high for 8 cycles;
  - done pulses for 1 cycle on the 9th edge;
  - diff_out = 0x1E, borrow_out = 0.
- Wrap and borrow cases:
  - a_in = 0x00, b_in = 0x01, borrow_in = 0 → diff_out = 0xFF, borrow_out = 1.
  - a_in = 0x10, b_in = 0x10, borrow_in = 1 → diff_out = 0xFF, borrow_out = 1.
  - a_in = 0xFF, b_in = 0x00, borrow_in = 1 → diff_out = 0xFE, borrow_out = 0.
- Protocol: start 0x80 − 0x01.
  - During RUN, change a_in to 0x00 and pulse start → ignored; result is 0x7F, borrow_out = 0.
  - Assert start again during the done cycle with 0x03 − 0x05 → accepted immediately; 9 edges later diff_out = 0xFE, borrow_out = 1.
  - diff_out holds 0x7F for the whole second RUN.
- Reset mid-operation: assert rst_n = 0 after the 4th RUN edge → all outputs 0. After release, a new 0x5A − 0x3C completes correctly with 0x1E.
- WIDTH = 3 exhaustive sweep: all 128 (a_in, b_in, borrow_in) combinations → diff_out and borrow_out match a reference model; exactly one done pulse per start.
